// File: rtl/gesture_pkg.sv
// Shared definitions for the gesture LED indicator block.
// Holds the gesture code constants, the one-hot LED patterns for each
// gesture and the two-state display FSM encoding.
package gesture_pkg;

  // Gesture codes reported on last_gesture (5..7 are unused)
  localparam logic [2:0] GEST_NONE = 3'd0;
  localparam logic [2:0] GEST_L2R  = 3'd1;
  localparam logic [2:0] GEST_R2L  = 3'd2;
  localparam logic [2:0] GEST_U2D  = 3'd3;
  localparam logic [2:0] GEST_D2U  = 3'd4;

  // One-hot LED patterns
  localparam logic [3:0] LED_OFF = 4'b0000;
  localparam logic [3:0] LED_L2R = 4'b0001;
  localparam logic [3:0] LED_R2L = 4'b0010;
  localparam logic [3:0] LED_U2D = 4'b0100;
  localparam logic [3:0] LED_D2U = 4'b1000;

  // Display FSM states
  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } gest_state_e;

endpackage

// File: rtl/gesture_rise_sync.sv
// Two-flop synchroniser plus rising-edge detector for one detect flag.
// Both flops reset to 1 so that a level already high when reset is
// released is treated as "old" and never reported as a rise.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset
//   level - raw detect level from the gesture core
//   rise  - high for one cycle after a 0->1 transition of level
module gesture_rise_sync
  import gesture_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic s1_r;
  logic s2_r;

  // Sample the detect level into a two-stage shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r <= 1'b1;
      s2_r <= 1'b1;
    end else begin
      s1_r <= level;
      s2_r <= s1_r;
    end
  end

  assign rise = s1_r & ~s2_r;

endmodule

// File: rtl/gesture_led_indicator.sv
// Gesture LED indicator: converts the gesture core's level-type detect
// flags into single accepted events, shows a one-hot LED pattern for
// HOLD_CYCLES cycles per event, remembers the last gesture and keeps a
// saturating event count.
// Ports:
//   clk          - system clock
//   reset        - synchronous, active-high reset
//   decide_flag  - detection-valid qualifier (level)
//   detect_l2r/r2l/u2d/d2u - direction detect flags (level)
//   led          - one-hot gesture pattern, 0 when idle
//   last_gesture - code of the most recent accepted gesture
//   event_valid  - one-cycle pulse per accepted event
//   event_count  - saturating count of accepted events
//   busy         - high while an LED pattern is being held
module gesture_led_indicator
  import gesture_pkg::*;
#(
  parameter int HOLD_CYCLES = 25000000,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             decide_flag,
  input  logic             detect_l2r,
  input  logic             detect_r2l,
  input  logic             detect_u2d,
  input  logic             detect_d2u,
  output logic [3:0]       led,
  output logic [2:0]       last_gesture,
  output logic             event_valid,
  output logic [CNT_W-1:0] event_count,
  output logic             busy
);

  localparam int TIMER_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

  // Bit order: 0 L2R, 1 R2L, 2 U2D, 3 D2U
  logic [3:0] rise_s;
  logic [3:0] cand_s;
  logic       dq_r;

  logic       accept_s;
  logic [2:0] win_code_s;
  logic [3:0] win_led_s;

  gest_state_e        state_r, state_n;
  logic [TIMER_W-1:0] timer_r, timer_n;
  logic [3:0]         led_r, led_n;
  logic [2:0]         last_r, last_n;
  logic               ev_r, ev_n;
  logic [CNT_W-1:0]   cnt_r, cnt_n;
  logic               busy_r, busy_n;

  gesture_rise_sync u_sync_l2r (.clk(clk), .reset(reset), .level(detect_l2r), .rise(rise_s[0]));
  gesture_rise_sync u_sync_r2l (.clk(clk), .reset(reset), .level(detect_r2l), .rise(rise_s[1]));
  gesture_rise_sync u_sync_u2d (.clk(clk), .reset(reset), .level(detect_u2d), .rise(rise_s[2]));
  gesture_rise_sync u_sync_d2u (.clk(clk), .reset(reset), .level(detect_d2u), .rise(rise_s[3]));

  // Register the decide qualifier once so it lines up with the rise pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      dq_r <= 1'b0;
    end else begin
      dq_r <= decide_flag;
    end
  end

  // A rise only counts while the qualifier is high; it is not remembered otherwise
  assign cand_s = rise_s & {4{dq_r}};

  // Fixed-priority pick of one winner; losing candidates are dropped
  always_comb begin
    accept_s   = 1'b0;
    win_code_s = GEST_NONE;
    win_led_s  = LED_OFF;
    if (cand_s[0]) begin
      accept_s   = 1'b1;
      win_code_s = GEST_L2R;
      win_led_s  = LED_L2R;
    end else if (cand_s[1]) begin
      accept_s   = 1'b1;
      win_code_s = GEST_R2L;
      win_led_s  = LED_R2L;
    end else if (cand_s[2]) begin
      accept_s   = 1'b1;
      win_code_s = GEST_U2D;
      win_led_s  = LED_U2D;
    end else if (cand_s[3]) begin
      accept_s   = 1'b1;
      win_code_s = GEST_D2U;
      win_led_s  = LED_D2U;
    end else begin
      accept_s   = 1'b0;
      win_code_s = GEST_NONE;
      win_led_s  = LED_OFF;
    end
  end

  // Next-state logic for the display FSM, hold timer, counter and outputs
  always_comb begin
    state_n = state_r;
    timer_n = timer_r;
    led_n   = led_r;
    busy_n  = busy_r;
    last_n  = last_r;
    cnt_n   = cnt_r;
    ev_n    = 1'b0;

    if (accept_s) begin
      ev_n   = 1'b1;
      last_n = win_code_s;
      if (cnt_r != CNT_MAX) begin
        cnt_n = cnt_r + CNT_W'(1);
      end else begin
        cnt_n = cnt_r;
      end
    end else begin
      ev_n = 1'b0;
    end

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_n = SHOW;
          timer_n = TIMER_LOAD;
          led_n   = win_led_s;
          busy_n  = 1'b1;
        end else begin
          timer_n = '0;
          led_n   = LED_OFF;
          busy_n  = 1'b0;
        end
      end
      SHOW: begin
        // A new event wins over expiry, even on the last lit cycle
        if (accept_s) begin
          timer_n = TIMER_LOAD;
          led_n   = win_led_s;
          busy_n  = 1'b1;
        end else if (timer_r != '0) begin
          timer_n = timer_r - TIMER_W'(1);
        end else begin
          state_n = IDLE;
          led_n   = LED_OFF;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
        led_n   = LED_OFF;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      timer_r <= '0;
      led_r   <= LED_OFF;
      busy_r  <= 1'b0;
      last_r  <= GEST_NONE;
      ev_r    <= 1'b0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      timer_r <= timer_n;
      led_r   <= led_n;
      busy_r  <= busy_n;
      last_r  <= last_n;
      ev_r    <= ev_n;
      cnt_r   <= cnt_n;
    end
  end

  assign led          = led_r;
  assign last_gesture = last_r;
  assign event_valid  = ev_r;
  assign event_count  = cnt_r;
  assign busy         = busy_r;

endmodule
